// File: rtl/image_line_rd_scheduler.sv
// Line-buffer read scheduler for a scaler: walks the destination raster,
// issues source column reads and releases consumed source rows.
module image_line_rd_scheduler (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [10:0] img_width,
   input  logic [10:0] src_height,
   input  logic [10:0] dst_width,
   input  logic [10:0] dst_height,
   input  logic [15:0] x_step,
   input  logic [15:0] y_step,
   input  logic        rd_ready,
   input  logic        src_frame_done,
   input  logic        dst_ready,
   output logic        rd_en,
   output logic [10:0] rd_addr,
   output logic        rd_finish,
   output logic [11:0] frac_x_o,
   output logic [11:0] frac_y_o,
   output logic        meta_valid_o,
   output logic        last_col_o,
   output logic        last_row_o,
   output logic        busy,
   output logic        done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_LINE  = 3'd2;
   localparam logic [2:0] S_ADV   = 3'd3;
   localparam logic [2:0] S_FLUSH = 3'd4;

   logic [2:0]  r_state;
   logic [10:0] r_img_w;
   logic [10:0] r_src_h;
   logic [10:0] r_dst_w;
   logic [10:0] r_dst_h;
   logic [15:0] r_x_step;
   logic [15:0] r_y_step;
   logic [22:0] r_x_acc;
   logic [22:0] r_y_acc;
   logic [10:0] r_out_row;
   logic [10:0] r_col;
   logic [10:0] r_rel_cnt;

   logic        r_p1_vld, r_p2_vld;
   logic [11:0] r_p1_fx, r_p2_fx;
   logic [11:0] r_p1_fy, r_p2_fy;
   logic        r_p1_lc, r_p2_lc;
   logic        r_p1_lr, r_p2_lr;

   logic [10:0] w_x_int;
   logic [10:0] w_img_max;
   logic [10:0] w_addr;
   logic [10:0] w_y_int;
   logic [10:0] w_rel_lim;
   logic [10:0] w_adv_lim;
   logic [23:0] w_x_sum;
   logic [23:0] w_y_sum;
   logic [22:0] w_x_next;
   logic [22:0] w_y_next;
   logic        w_last_col;
   logic        w_last_row;
   logic        w_adv_rel;
   logic        w_flush_go;
   logic        w_flush_rel;

   assign w_x_int   = r_x_acc[22:12];
   assign w_img_max = r_img_w - 11'd1;
   assign w_addr    = (w_x_int > w_img_max) ? w_img_max : w_x_int;
   assign w_y_int   = r_y_acc[22:12];
   // Keep the last three source rows resident until the frame flush.
   assign w_rel_lim = (r_src_h < 11'd3) ? 11'd0 : r_src_h - 11'd3;
   assign w_adv_lim = (w_y_int < w_rel_lim) ? w_y_int : w_rel_lim;

   // Accumulators saturate instead of wrapping.
   assign w_x_sum  = {1'b0, r_x_acc} + {8'd0, r_x_step};
   assign w_y_sum  = {1'b0, r_y_acc} + {8'd0, r_y_step};
   assign w_x_next = w_x_sum[23] ? '1 : w_x_sum[22:0];
   assign w_y_next = w_y_sum[23] ? '1 : w_y_sum[22:0];

   assign w_last_col  = (r_col == r_dst_w - 11'd1);
   assign w_last_row  = (r_out_row == r_dst_h - 11'd1);
   assign w_adv_rel   = (r_state == S_ADV) && (r_rel_cnt < w_adv_lim);
   assign w_flush_go  = (r_state == S_FLUSH) && src_frame_done;
   assign w_flush_rel = w_flush_go && (r_rel_cnt < r_src_h);

   assign rd_en     = (r_state == S_LINE) && dst_ready;
   assign rd_addr   = rd_en ? w_addr : 11'd0;
   assign rd_finish = w_adv_rel | w_flush_rel;
   assign done      = w_flush_go && !(r_rel_cnt < r_src_h);
   assign busy      = (r_state != S_IDLE);

   assign meta_valid_o = r_p2_vld;
   assign frac_x_o     = r_p2_fx;
   assign frac_y_o     = r_p2_fy;
   assign last_col_o   = r_p2_lc;
   assign last_row_o   = r_p2_lr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_img_w   <= '0;
         r_src_h   <= '0;
         r_dst_w   <= '0;
         r_dst_h   <= '0;
         r_x_step  <= '0;
         r_y_step  <= '0;
         r_x_acc   <= '0;
         r_y_acc   <= '0;
         r_out_row <= '0;
         r_col     <= '0;
         r_rel_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_img_w   <= img_width;
                  r_src_h   <= src_height;
                  r_dst_w   <= dst_width;
                  r_dst_h   <= dst_height;
                  r_x_step  <= x_step;
                  r_y_step  <= y_step;
                  r_x_acc   <= '0;
                  r_y_acc   <= '0;
                  r_out_row <= '0;
                  r_col     <= '0;
                  r_rel_cnt <= '0;
                  r_state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (rd_ready) begin
                  r_x_acc <= '0;
                  r_col   <= '0;
                  r_state <= S_LINE;
               end
            end
            S_LINE: begin
               if (dst_ready) begin
                  r_x_acc <= w_x_next;
                  r_col   <= r_col + 11'd1;
                  if (w_last_col) begin
                     r_y_acc <= w_y_next;
                     r_state <= S_ADV;
                  end
               end
            end
            S_ADV: begin
               if (w_adv_rel) begin
                  r_rel_cnt <= r_rel_cnt + 11'd1;
               end else if (!w_last_row) begin
                  r_out_row <= r_out_row + 11'd1;
                  r_state   <= S_WAIT;
               end else begin
                  r_state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (w_flush_rel) begin
                  r_rel_cnt <= r_rel_cnt + 11'd1;
               end else if (w_flush_go) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Metadata rides two stages to line up with the buffer's read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p1_vld <= 1'b0;
         r_p1_fx  <= '0;
         r_p1_fy  <= '0;
         r_p1_lc  <= 1'b0;
         r_p1_lr  <= 1'b0;
         r_p2_vld <= 1'b0;
         r_p2_fx  <= '0;
         r_p2_fy  <= '0;
         r_p2_lc  <= 1'b0;
         r_p2_lr  <= 1'b0;
      end else begin
         r_p1_vld <= rd_en;
         r_p1_fx  <= rd_en ? r_x_acc[11:0] : 12'd0;
         r_p1_fy  <= rd_en ? r_y_acc[11:0] : 12'd0;
         r_p1_lc  <= rd_en && w_last_col;
         r_p1_lr  <= rd_en && w_last_row;
         r_p2_vld <= r_p1_vld;
         r_p2_fx  <= r_p1_fx;
         r_p2_fy  <= r_p1_fy;
         r_p2_lc  <= r_p1_lc;
         r_p2_lr  <= r_p1_lr;
      end
   end

endmodule

// File: tb/tb_image_line_rd_scheduler.sv
// Randomized scoreboard bench for image_line_rd_scheduler against a
// raster-walk reference model of the destination frame.
module tb_image_line_rd_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] img_width = '0;
   logic [10:0] src_height = '0;
   logic [10:0] dst_width = '0;
   logic [10:0] dst_height = '0;
   logic [15:0] x_step = '0;
   logic [15:0] y_step = '0;
   logic        rd_ready = 1'b0;
   logic        src_frame_done = 1'b0;
   logic        dst_ready = 1'b0;
   logic        rd_en;
   logic [10:0] rd_addr;
   logic        rd_finish;
   logic [11:0] frac_x_o;
   logic [11:0] frac_y_o;
   logic        meta_valid_o;
   logic        last_col_o;
   logic        last_row_o;
   logic        busy;
   logic        done;

   image_line_rd_scheduler dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .img_width(img_width), .src_height(src_height),
      .dst_width(dst_width), .dst_height(dst_height),
      .x_step(x_step), .y_step(y_step),
      .rd_ready(rd_ready), .src_frame_done(src_frame_done),
      .dst_ready(dst_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_finish(rd_finish),
      .frac_x_o(frac_x_o), .frac_y_o(frac_y_o),
      .meta_valid_o(meta_valid_o), .last_col_o(last_col_o),
      .last_row_o(last_row_o), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   localparam longint ACC_MAX = (64'd1 << 23) - 1;

   int checks = 0;
   int failures = 0;
   int fin_cnt = 0;
   int done_cnt = 0;
   int rd_seen = 0;
   bit rand_mode = 1'b1;

   logic [10:0] q_addr[$];
   logic [25:0] q_meta[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected requests: destination pixel (r,c) samples source x=c*xs, y=r*ys.
   task automatic push_frame(input int iw, input int dw, input int dh,
                             input int xs, input int ys);
      longint xa, ya, a;
      for (int r = 0; r < dh; r++) begin
         ya = longint'(r) * ys;
         if (ya > ACC_MAX) ya = ACC_MAX;
         for (int c = 0; c < dw; c++) begin
            xa = longint'(c) * xs;
            if (xa > ACC_MAX) xa = ACC_MAX;
            a = xa >> 12;
            if (a > iw - 1) a = iw - 1;
            q_addr.push_back(11'(a));
            q_meta.push_back({(c == dw - 1), (r == dh - 1),
                              12'(xa & 12'hfff), 12'(ya & 12'hfff)});
         end
      end
   endtask

   function automatic int exp_adv(input int sh, input int dh, input int ys);
      longint ya, yi;
      ya = longint'(dh) * ys;
      if (ya > ACC_MAX) ya = ACC_MAX;
      yi = ya >> 12;
      if (yi > sh - 3) yi = sh - 3;
      return int'(yi);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) begin
            dst_ready = ($urandom % 10) < 6;
            rd_ready  = ($urandom % 10) < 7;
         end else begin
            dst_ready = 1'b1;
            rd_ready  = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a request or metadata.
   initial begin
      logic [25:0] m;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (rd_en) begin
               chk("rd_en_vs_rd_finish", rd_finish, 0);
               chk("rd_en_without_dst_ready", dst_ready, 1);
               if (q_addr.size() == 0) chk("unexpected_rd_en", 1, 0);
               else chk("rd_addr", rd_addr, q_addr.pop_front());
               rd_seen++;
            end
            if (meta_valid_o) begin
               if (q_meta.size() == 0) begin
                  chk("unexpected_meta", 1, 0);
               end else begin
                  m = q_meta.pop_front();
                  chk("last_col", last_col_o, m[25]);
                  chk("last_row", last_row_o, m[24]);
                  chk("frac_x", frac_x_o, m[23:12]);
                  chk("frac_y", frac_y_o, m[11:0]);
               end
            end
            if (rd_finish) fin_cnt++;
            if (done) done_cnt++;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      src_frame_done = 1'b0;
      start = 1'b0;
      q_addr.delete();
      q_meta.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic kick(input int iw, input int sh, input int dw,
                       input int dh, input int xs, input int ys);
      @(posedge clk);
      #1;
      img_width  = 11'(iw);
      src_height = 11'(sh);
      dst_width  = 11'(dw);
      dst_height = 11'(dh);
      x_step     = 16'(xs);
      y_step     = 16'(ys);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input int iw, input int sh, input int dw,
                            input int dh, input int xs, input int ys,
                            input bit restart_poke);
      int n;
      push_frame(iw, dw, dh, xs, ys);
      fin_cnt = 0;
      done_cnt = 0;
      kick(iw, sh, dw, dh, xs, ys);
      if (restart_poke) begin
         repeat (4) @(posedge clk);
         #1;
         img_width  = 11'($urandom_range(1, 30));
         src_height = 11'($urandom_range(3, 30));
         dst_width  = 11'($urandom_range(1, 30));
         dst_height = 11'($urandom_range(1, 30));
         x_step     = 16'($urandom);
         y_step     = 16'($urandom);
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      n = 0;
      while ((q_addr.size() != 0 || q_meta.size() != 0) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 20000) begin
         chk("frame_requests_timeout", 0, 1);
         do_reset();
         return;
      end
      repeat (sh + 10) @(posedge clk);
      #1;
      chk("advance_releases", fin_cnt, exp_adv(sh, dh, ys));
      chk("busy_before_flush", busy, 1);
      chk("done_before_flush", done_cnt, 0);
      src_frame_done = 1'b1;
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (n >= 200) chk("flush_done_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("total_releases", fin_cnt, sh);
      chk("done_pulses", done_cnt, 1);
      chk("busy_after_done", busy, 0);
      src_frame_done = 1'b0;
      if (busy) do_reset();
   endtask

   task automatic reset_mid_line();
      int n;
      rand_mode = 1'b0;
      push_frame(16, 12, 4, 32'h1000, 32'h1000);
      rd_seen = 0;
      kick(16, 8, 12, 4, 32'h1000, 32'h1000);
      n = 0;
      while (rd_seen < 6 && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("reach_col5", (rd_seen >= 6), 1);
      chk("rd_en_before_reset", rd_en, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_rd_en", rd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_rd_finish", rd_finish, 0);
      chk("rst_meta_valid", meta_valid_o, 0);
      chk("rst_frac_x", frac_x_o, 0);
      q_addr.delete();
      q_meta.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      run_frame(16, 8, 12, 4, 32'h1000, 32'h1000, 1'b0);
      rand_mode = 1'b1;
   endtask

   initial begin
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_rd_en", rd_en, 0);
      chk("reset_meta_valid", meta_valid_o, 0);
      chk("reset_done", done, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_rd_finish", rd_finish, 0);
      chk("idle_meta_valid", meta_valid_o, 0);
      chk("idle_rd_en", rd_en, 0);

      rand_mode = 1'b0;
      run_frame(8, 8, 16, 16, 32'h0800, 32'h0800, 1'b0);
      run_frame(4, 4, 4, 1, 32'h1800, 32'h1000, 1'b0);
      run_frame(4, 4, 4, 4, 32'h1000, 32'h1000, 1'b0);
      run_frame(8, 6, 1, 1, 32'h1000, 32'h1000, 1'b0);
      rand_mode = 1'b1;
      run_frame(8, 6, 5, 3, 32'h1000, 32'h0000, 1'b0);
      run_frame(8, 8, 16, 16, 32'h0800, 32'h0800, 1'b1);
      reset_mid_line();

      for (int i = 0; i < 12; i++) begin
         run_frame($urandom_range(1, 16), $urandom_range(3, 16),
                   $urandom_range(1, 16), $urandom_range(1, 8),
                   $urandom_range(0, 32'h3000),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 32'h2000),
                   ($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
